// File: rtl/project_mux_pkg.sv
// Shared definitions for the project IO multiplexer: FSM states, safe pad values
// and request-vector helpers.
package project_mux_pkg;

  localparam int unsigned MAX_PROJECTS = 32;
  localparam int unsigned MAX_IDX_W    = $clog2(MAX_PROJECTS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GAP    = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  // Per-bit safe pad values; replicate to the pad width at the use site.
  localparam logic SAFE_OUT_BIT = 1'b0;
  localparam logic SAFE_OEB_BIT = 1'b1;

  function automatic int unsigned onehot_to_index(input logic [MAX_PROJECTS-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_PROJECTS; i++) begin
      if (v[MAX_IDX_W'(i)]) idx = idx | i;
    end
    return idx;
  endfunction

  function automatic logic more_than_one(input logic [MAX_PROJECTS-1:0] v);
    return (v & (v - MAX_PROJECTS'(1))) != '0;
  endfunction

endpackage

// File: rtl/request_qualifier.sv
// Registers the LA request vector, tracks how long it has been unchanged and
// decodes it into a target project index.
module request_qualifier
  import project_mux_pkg::*;
#(
  parameter int unsigned NUM_PROJECTS  = 8,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SEL_W         = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PROJECTS-1:0] req,
  output logic [SEL_W-1:0]        target_idx,
  output logic                    target_valid,
  output logic                    stable,
  output logic                    conflict
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [NUM_PROJECTS-1:0] req_q;
  logic [CNT_W-1:0]        stab_cnt;

  // Stability counter restarts on the same edge that loads a new request value.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '0;
      stab_cnt <= '0;
      conflict <= 1'b0;
    end else begin
      req_q    <= req;
      conflict <= more_than_one(MAX_PROJECTS'(req));
      if (req != req_q) begin
        stab_cnt <= '0;
      end else if (stab_cnt != CNT_W'(STABLE_CYCLES)) begin
        stab_cnt <= stab_cnt + CNT_W'(1);
      end
    end
  end

  assign target_valid = (req_q != '0) && !conflict;
  assign target_idx   = SEL_W'(onehot_to_index(MAX_PROJECTS'(req_q)));
  assign stable       = stab_cnt >= CNT_W'(STABLE_CYCLES - 1);

endmodule

// File: rtl/project_io_mux.sv
// Registered, glitch-free selection of one wrapped project onto the user IO pads
// and LA return bus, with a tristated hold-off gap on every change of owner.
module project_io_mux
  import project_mux_pkg::*;
#(
  parameter int unsigned         NUM_PROJECTS  = 8,
  parameter int unsigned         IO_WIDTH      = 38,
  parameter int unsigned         LA_WIDTH      = 32,
  parameter int unsigned         STABLE_CYCLES = 4,
  parameter int unsigned         HOLDOFF       = 2,
  parameter logic [IO_WIDTH-1:0] IO_KEEP_MASK  = '0,
  localparam int unsigned        SEL_W         = $clog2(NUM_PROJECTS)
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic [NUM_PROJECTS-1:0]          req_i,
  input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_out_i,
  input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_oeb_i,
  input  logic [NUM_PROJECTS*LA_WIDTH-1:0] proj_la_out_i,
  output logic [NUM_PROJECTS-1:0]          proj_active_o,
  output logic [IO_WIDTH-1:0]              io_out,
  output logic [IO_WIDTH-1:0]              io_oeb,
  output logic [LA_WIDTH-1:0]              la_data_out,
  output logic [SEL_W-1:0]                 sel_idx_o,
  output logic                             sel_valid_o,
  output logic                             busy_o,
  output logic                             conflict_o
);

  localparam int unsigned         GAP_W    = $clog2(HOLDOFF + 1);
  localparam logic [IO_WIDTH-1:0] SAFE_OUT = {IO_WIDTH{SAFE_OUT_BIT}};
  localparam logic [IO_WIDTH-1:0] SAFE_OEB = {IO_WIDTH{SAFE_OEB_BIT}};

  logic [SEL_W-1:0] target_idx;
  logic             target_valid;
  logic             stable;

  request_qualifier #(
    .NUM_PROJECTS  (NUM_PROJECTS),
    .STABLE_CYCLES (STABLE_CYCLES),
    .SEL_W         (SEL_W)
  ) u_qual (
    .clk          (wb_clk_i),
    .rst          (wb_rst_i),
    .req          (req_i),
    .target_idx   (target_idx),
    .target_valid (target_valid),
    .stable       (stable),
    .conflict     (conflict_o)
  );

  logic [IO_WIDTH-1:0] out_arr [NUM_PROJECTS];
  logic [IO_WIDTH-1:0] oeb_arr [NUM_PROJECTS];
  logic [LA_WIDTH-1:0] la_arr  [NUM_PROJECTS];

  for (genvar k = 0; k < NUM_PROJECTS; k++) begin : g_slice
    assign out_arr[k] = proj_io_out_i[k*IO_WIDTH +: IO_WIDTH];
    assign oeb_arr[k] = proj_io_oeb_i[k*IO_WIDTH +: IO_WIDTH];
    assign la_arr[k]  = proj_la_out_i[k*LA_WIDTH +: LA_WIDTH];
  end

  logic [1:0]              state_q, state_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    drive;
  logic [NUM_PROJECTS-1:0] active_d;
  logic [IO_WIDTH-1:0]     io_out_d, io_oeb_d;
  logic [LA_WIDTH-1:0]     la_d;

  // Pads are driven only while the owner is kept across the edge, so a release
  // and the following grant both start from safe values.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    sel_d    = sel_q;
    io_out_d = SAFE_OUT;
    io_oeb_d = SAFE_OEB;
    la_d     = '0;

    case (state_q)
      IDLE: begin
        if (stable && target_valid) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      ACTIVE: begin
        if (stable && !(target_valid && (target_idx == sel_q))) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q != GAP_W'(HOLDOFF - 1)) begin
          gap_d = gap_q + GAP_W'(1);
        end else if (stable) begin
          if (target_valid) begin
            state_d = ACTIVE;
            sel_d   = target_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    drive = (state_q == ACTIVE) && (state_d == ACTIVE);
    if (drive) begin
      io_out_d = out_arr[sel_q] & ~IO_KEEP_MASK;
      io_oeb_d = oeb_arr[sel_q] | IO_KEEP_MASK;
      la_d     = la_arr[sel_q];
    end
    active_d = (state_d == ACTIVE) ? (NUM_PROJECTS'(1) << sel_d) : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      gap_q         <= '0;
      sel_q         <= '0;
      proj_active_o <= '0;
      io_out        <= SAFE_OUT;
      io_oeb        <= SAFE_OEB;
      la_data_out   <= '0;
      sel_valid_o   <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      sel_q         <= sel_d;
      proj_active_o <= active_d;
      io_out        <= io_out_d;
      io_oeb        <= io_oeb_d;
      la_data_out   <= la_d;
      sel_valid_o   <= (state_d == ACTIVE);
      busy_o        <= (state_d == GAP);
    end
  end

  assign sel_idx_o = sel_q;

endmodule

// File: tb/tb_project_io_mux.sv
// Bench for project_io_mux: hand-derived directed table plus randomized requests
// checked every cycle against a behavioural ownership model.
module tb_project_io_mux;

  localparam int unsigned NP   = 8;
  localparam int unsigned IO   = 38;
  localparam int unsigned LA   = 32;
  localparam int unsigned S    = 4;
  localparam int unsigned H    = 2;
  localparam logic [IO-1:0] KEEP = 38'h1F;
  localparam logic [IO-1:0] ALL1 = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             wb_rst_i;
  logic [NP-1:0]    req_i;
  logic [NP*IO-1:0] proj_io_out_i, proj_io_oeb_i;
  logic [NP*LA-1:0] proj_la_out_i;
  logic [NP-1:0]    proj_active_o;
  logic [IO-1:0]    io_out, io_oeb;
  logic [LA-1:0]    la_data_out;
  logic [2:0]       sel_idx_o;
  logic             sel_valid_o, busy_o, conflict_o;

  logic [IO-1:0] p_out [NP];
  logic [IO-1:0] p_oeb [NP];
  logic [LA-1:0] p_la  [NP];

  always_comb begin
    for (int k = 0; k < NP; k++) begin
      proj_io_out_i[k*IO +: IO] = p_out[k];
      proj_io_oeb_i[k*IO +: IO] = p_oeb[k];
      proj_la_out_i[k*LA +: LA] = p_la[k];
    end
  end

  project_io_mux #(
    .NUM_PROJECTS (NP), .IO_WIDTH (IO), .LA_WIDTH (LA),
    .STABLE_CYCLES (S), .HOLDOFF (H), .IO_KEEP_MASK (KEEP)
  ) dut (
    .wb_clk_i (clk), .wb_rst_i (wb_rst_i), .req_i (req_i),
    .proj_io_out_i (proj_io_out_i), .proj_io_oeb_i (proj_io_oeb_i),
    .proj_la_out_i (proj_la_out_i), .proj_active_o (proj_active_o),
    .io_out (io_out), .io_oeb (io_oeb), .la_data_out (la_data_out),
    .sel_idx_o (sel_idx_o), .sel_valid_o (sel_valid_o),
    .busy_o (busy_o), .conflict_o (conflict_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: ownership mode 0=idle 1=gap 2=active, history of registered requests.
  logic [NP-1:0] hist[$];
  int            m_mode;
  int            m_gapc;
  logic [2:0]    m_owner;
  logic          m_conf;
  logic [IO-1:0] e_out, e_oeb;
  logic [LA-1:0] e_la;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, want);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [NP-1:0] req);
    logic          stab, tgt_ok, drive;
    logic [2:0]    tgt;
    logic [NP-1:0] last;
    int            prev;
    if (rst) begin
      hist.delete();
      hist.push_back('0);
      m_mode = 0; m_gapc = 0; m_owner = '0; m_conf = 1'b0;
      e_out = '0; e_oeb = ALL1; e_la = '0;
    end else begin
      last = hist[$];
      stab = (hist.size() >= S);
      foreach (hist[i]) if (hist[i] != last) stab = 1'b0;
      tgt_ok = ($countones(last) == 1);
      tgt = '0;
      for (int i = 0; i < NP; i++) if (last == (8'(1) << i)) tgt = 3'(i);
      prev = m_mode;
      case (m_mode)
        0: if (stab && tgt_ok) begin m_mode = 1; m_gapc = 1; end
        2: if (stab && !(tgt_ok && tgt == m_owner)) begin m_mode = 1; m_gapc = 1; end
        default: begin
          if (m_gapc < H) m_gapc++;
          else if (stab) begin
            if (tgt_ok) begin m_mode = 2; m_owner = tgt; end
            else m_mode = 0;
          end
        end
      endcase
      drive = (prev == 2) && (m_mode == 2);
      e_out = drive ? (p_out[m_owner] & ~KEEP) : '0;
      e_oeb = drive ? (p_oeb[m_owner] | KEEP) : ALL1;
      e_la  = drive ? p_la[m_owner] : '0;
      hist.push_back(req);
      if (hist.size() > S) void'(hist.pop_front());
      m_conf = ($countones(req) > 1);
    end
  endtask

  task automatic compare_all();
    chk("active",   64'(proj_active_o), 64'((m_mode == 2) ? (8'(1) << m_owner) : 8'h00));
    chk("io_out",   64'(io_out),        64'(e_out));
    chk("io_oeb",   64'(io_oeb),        64'(e_oeb));
    chk("la",       64'(la_data_out),   64'(e_la));
    chk("sel_idx",  64'(sel_idx_o),     64'(m_owner));
    chk("valid",    64'(sel_valid_o),   64'(m_mode == 2));
    chk("busy",     64'(busy_o),        64'(m_mode == 1));
    chk("conflict", 64'(conflict_o),    64'(m_conf));
    chk("onehot",   64'($countones(proj_active_o) <= 1), 64'(1));
  endtask

  task automatic step(input logic rst, input logic [NP-1:0] req);
    wb_rst_i = rst;
    req_i    = req;
    @(posedge clk);
    model_edge(rst, req);
    #1;
    cyc++;
    compare_all();
  endtask

  typedef struct {
    logic          rst;
    logic [NP-1:0] req;
    int            cycles;
    logic [NP-1:0] act;
    logic          valid;
    logic          busy;
    logic          conf;
    logic [2:0]    sel;
    logic [IO-1:0] out;
    logic [IO-1:0] oeb;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [NP-1:0] req, input int cycles,
                              input logic [NP-1:0] act, input logic valid, input logic busy,
                              input logic conf, input logic [2:0] sel,
                              input logic [IO-1:0] out, input logic [IO-1:0] oeb);
    vec_t v;
    v.rst = rst; v.req = req; v.cycles = cycles; v.act = act; v.valid = valid;
    v.busy = busy; v.conf = conf; v.sel = sel; v.out = out; v.oeb = oeb;
    return v;
  endfunction

  vec_t tbl[24];

  initial begin
    // Project 2 drives 0x155, project 4 drives 0x40AA; pads 0-4 are kept as inputs.
    for (int k = 0; k < NP; k++) begin
      p_out[k] = (k == 2) ? 38'h155 : ((38'(k) << 12) | 38'hAA);
      p_oeb[k] = '0;
      p_la[k]  = 32'hA000_0000 | 32'(k);
    end
    wb_rst_i = 1'b1;
    req_i    = '0;

    tbl[0]  = mk(1, 8'h00, 1,  8'h00, 0, 0, 0, 3'd0, 38'h0,   ALL1);
    tbl[1]  = mk(0, 8'h00, 20, 8'h00, 0, 0, 0, 3'd0, 38'h0,   ALL1);
    tbl[2]  = mk(0, 8'h04, 5,  8'h00, 0, 1, 0, 3'd0, 38'h0,   ALL1);
    tbl[3]  = mk(0, 8'h04, 1,  8'h00, 0, 1, 0, 3'd0, 38'h0,   ALL1);
    tbl[4]  = mk(0, 8'h04, 1,  8'h04, 1, 0, 0, 3'd2, 38'h0,   ALL1);
    tbl[5]  = mk(0, 8'h04, 1,  8'h04, 1, 0, 0, 3'd2, 38'h140, 38'h1F);
    tbl[6]  = mk(0, 8'h10, 4,  8'h04, 1, 0, 0, 3'd2, 38'h140, 38'h1F);
    tbl[7]  = mk(0, 8'h10, 1,  8'h00, 0, 1, 0, 3'd2, 38'h0,   ALL1);
    tbl[8]  = mk(0, 8'h10, 1,  8'h00, 0, 1, 0, 3'd2, 38'h0,   ALL1);
    tbl[9]  = mk(0, 8'h10, 1,  8'h10, 1, 0, 0, 3'd4, 38'h0,   ALL1);
    tbl[10] = mk(0, 8'h10, 1,  8'h10, 1, 0, 0, 3'd4, 38'h40A0, 38'h1F);
    tbl[11] = mk(0, 8'h04, 7,  8'h04, 1, 0, 0, 3'd2, 38'h0,   ALL1);
    tbl[12] = mk(0, 8'h04, 1,  8'h04, 1, 0, 0, 3'd2, 38'h140, 38'h1F);
    tbl[13] = mk(0, 8'h0C, 1,  8'h04, 1, 0, 1, 3'd2, 38'h140, 38'h1F);
    tbl[14] = mk(0, 8'h0C, 4,  8'h00, 0, 1, 1, 3'd2, 38'h0,   ALL1);
    tbl[15] = mk(0, 8'h0C, 2,  8'h00, 0, 0, 1, 3'd2, 38'h0,   ALL1);
    tbl[16] = mk(0, 8'h04, 1,  8'h00, 0, 0, 0, 3'd2, 38'h0,   ALL1);
    tbl[17] = mk(0, 8'h04, 6,  8'h04, 1, 0, 0, 3'd2, 38'h0,   ALL1);
    tbl[18] = mk(0, 8'h04, 1,  8'h04, 1, 0, 0, 3'd2, 38'h140, 38'h1F);
    tbl[19] = mk(0, 8'h01, 3,  8'h04, 1, 0, 0, 3'd2, 38'h140, 38'h1F);
    tbl[20] = mk(0, 8'h04, 6,  8'h04, 1, 0, 0, 3'd2, 38'h140, 38'h1F);
    tbl[21] = mk(0, 8'h10, 5,  8'h00, 0, 1, 0, 3'd2, 38'h0,   ALL1);
    tbl[22] = mk(1, 8'h10, 1,  8'h00, 0, 0, 0, 3'd0, 38'h0,   ALL1);
    tbl[23] = mk(0, 8'h00, 8,  8'h00, 0, 0, 0, 3'd0, 38'h0,   ALL1);

    for (int i = 0; i < 24; i++) begin
      for (int c = 0; c < tbl[i].cycles; c++) step(tbl[i].rst, tbl[i].req);
      chk($sformatf("v%0d_active", i), 64'(proj_active_o), 64'(tbl[i].act));
      chk($sformatf("v%0d_valid", i),  64'(sel_valid_o),   64'(tbl[i].valid));
      chk($sformatf("v%0d_busy", i),   64'(busy_o),        64'(tbl[i].busy));
      chk($sformatf("v%0d_conf", i),   64'(conflict_o),    64'(tbl[i].conf));
      chk($sformatf("v%0d_sel", i),    64'(sel_idx_o),     64'(tbl[i].sel));
      chk($sformatf("v%0d_out", i),    64'(io_out),        64'(tbl[i].out));
      chk($sformatf("v%0d_oeb", i),    64'(io_oeb),        64'(tbl[i].oeb));
    end

    // Randomized requests with fresh project data every cycle and rare resets.
    for (int seg = 0; seg < 350; seg++) begin
      logic [NP-1:0] r;
      int            pick, hold;
      pick = int'($urandom_range(0, 9));
      if (pick < 2)      r = '0;
      else if (pick < 8) r = 8'(1) << $urandom_range(0, NP - 1);
      else               r = (8'(1) << $urandom_range(0, NP - 1)) | (8'(1) << $urandom_range(0, NP - 1));
      hold = int'($urandom_range(1, 9));
      for (int c = 0; c < hold; c++) begin
        for (int k = 0; k < NP; k++) begin
          p_out[k] = IO'({$urandom(), $urandom()});
          p_oeb[k] = IO'({$urandom(), $urandom()});
          p_la[k]  = LA'($urandom());
        end
        step(($urandom_range(0, 199) == 0), r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
